pipe_ctrl: RTL
==============

# pipe_ctrl

Central pipeline controller for the five-stage core. It merges stall requests from IF, ID, EX and MEM into the six-bit `stall` vector consumed by the PC register and every inter-stage register. It turns MEM-stage exceptions and ERET into a one-cycle registered `flush` with a redirect `new_pc`. It also keeps a stall-cycle counter and a stuck-pipeline watchdog for debug.

## Interface
- `WDOG_LIMIT`, default 1023: number of consecutive stalled cycles after which `hang` is set.
- `EXC_VECTOR`, default 32'h0000_0020: redirect target for every exception except ERET.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `stallreq_if`, in, 1: fetch wait, e.g. instruction bus not ready.
- `stallreq_id`, in, 1: load-use hazard.
- `stallreq_ex`, in, 1: multi-cycle EX operation (madd/msub/div) in progress.
- `stallreq_mem`, in, 1: data bus not ready.
- `excepttype`, in, 32: exception cause from MEM. 0 means none. 32'h0000_000e means ERET.
- `cp0_epc`, in, 32: current EPC, used as the ERET target.
- `stall`, out, 6: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB. 1 means hold.
- `flush`, out, 1: clear all pipeline registers this cycle.
- `new_pc`, out, 32: redirect address, valid while `flush`=1.
- `stall_cycles`, out, 32: count of cycles with `stall`≠0 since reset.
- `hang`, out, 1: sticky watchdog flag.

## Operation
- `stall` is combinational from the requests. Highest-index source wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 0
- A stage register whose own bit is set and whose successor's bit is clear inserts a bubble, so this encoding gives hold-upstream/bubble-downstream.
- FSM states:
  - RUN: normal operation. A nonzero `excepttype` moves to FLUSH and captures the target: `cp0_epc` if `excepttype`==32'h0000_000e, else `EXC_VECTOR`.
  - FLUSH: lasts exactly one cycle. `flush`=1, `new_pc`=captured target, `stall` forced to 0. Always returns to RUN.
- Exception input during FLUSH is ignored. The flushed MEM stage cannot hold a valid exception.
- Stall requests during FLUSH are ignored because `stall` is forced to 0.
- `stall_cycles` increments on every cycle with `stall`≠0 and wraps from 32'hFFFF_FFFF to 0.
- Watchdog:
  - A 10-bit run counter increments while `stall`≠0 and clears on any cycle with `stall`=0.
  - When the counter reaches `WDOG_LIMIT`, `hang` is set.
  - `hang` clears only on `rst`.
  - The run counter saturates at `WDOG_LIMIT` and does not wrap.
- `new_pc` holds its last captured value outside FLUSH. Consumers use it only when `flush`=1.

## Timing
- Reset values: state=RUN, `flush`=0, `new_pc`=0, `stall_cycles`=0, run counter=0, `hang`=0. `stall` follows its inputs combinationally, even during reset.
- `stall` has zero latency from the requests.
- `flush` is one-cycle latency: exception seen at edge N, `flush`=1 in cycle N+1 only.
- Exception and stall request in the same RUN cycle: `stall` still follows the request in that cycle, and FLUSH follows next cycle.
- `rst` asserted while in FLUSH returns to RUN at the next edge with `flush`=0.
- `hang` rises in the cycle after the counting edge that reaches `WDOG_LIMIT`.

## Structure
- Shared package / `define.v`:
  - stall-vector constants
  - `Stop`/`NoStop`
  - ERET cause code 32'h0000_000e
  - default exception vector
  - FSM state encodings
- Sub-module `stall_wdog`: holds the `stall_cycles` counter, the run counter and `hang`. Input is `stall_any`.
- The priority encoder and FSM stay in `pipe_ctrl`.

## Test plan
- Reset, then no requests → `stall`=0, `flush`=0, `stall_cycles`=0, `hang`=0.
- `stallreq_id`=1 and `stallreq_mem`=1 in the same cycle → `stall`=6'b011111. Drop `stallreq_mem` → `stall`=6'b000111.
- `excepttype`=32'h0000_0008 for one cycle → next cycle `flush`=1, `new_pc`=32'h0000_0020, `stall`=0. The cycle after that: `flush`=0.
- `excepttype`=32'h0000_000e with `cp0_epc`=32'h8000_0100 → next cycle `flush`=1, `new_pc`=32'h8000_0100.
- `stallreq_ex` held for 1023 cycles with `WDOG_LIMIT`=1023:
  - `hang`=1 after the 1023rd stalled cycle
  - `stall_cycles`=1023
  - `hang` stays 1 after the request drops
  - `rst` clears it
- Exception asserted, then `rst` during the FLUSH cycle → next cycle state=RUN, `flush`=0, `new_pc`=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall vectors, hold flags,
// exception cause codes, default exception vector and FSM state encoding.
package pipe_ctrl_pkg;

    // Stall vector bit order: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [31:0] EXC_NONE       = 32'h0000_0000;
    localparam logic [31:0] EXC_ERET       = 32'h0000_000e;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } pipe_state_e;

    // Highest-index requester wins; each level holds itself and everything upstream.
    function automatic logic [5:0] stall_encode(input logic req_if, input logic req_id,
                                                input logic req_ex, input logic req_mem);
        logic [5:0] vec;
        vec = STALL_NONE;
        if (req_mem == STOP)     vec = STALL_MEM;
        else if (req_ex == STOP) vec = STALL_EX;
        else if (req_id == STOP) vec = STALL_ID;
        else if (req_if == STOP) vec = STALL_IF;
        return vec;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of stall requests, exception inputs and control outputs between the
// pipeline stages and the controller. slave = controller side.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype;
    logic [31:0] cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic        hang;
    pipe_state_e state;          // debug view of the controller FSM

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
        output stall, flush, new_pc, stall_cycles, hang, state
    );

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
        input  stall, flush, new_pc, stall_cycles, hang, state
    );

endinterface

// File: rtl/pipe_ctrl_stall_wdog.sv
// Stall statistics: free-running stalled-cycle counter plus a watchdog that
// flags a pipeline stuck in stall for WDOG_LIMIT consecutive cycles.
module pipe_ctrl_stall_wdog
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WDOG_LIMIT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_any_i,
    output logic [31:0] stall_cycles_o,
    output logic        hang_o
);

    localparam logic [9:0] LIMIT = WDOG_LIMIT[9:0];

    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [9:0]  run_cnt_q, run_cnt_d;
    logic        hang_q, hang_d;

    // Next-state: total count wraps naturally, run count saturates, hang is sticky.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        run_cnt_d      = run_cnt_q;
        hang_d         = hang_q;
        if (stall_any_i == NO_STOP) begin
            run_cnt_d = 10'd0;
        end else begin
            stall_cycles_d = stall_cycles_q + 32'd1;
            if (run_cnt_q != LIMIT) run_cnt_d = run_cnt_q + 10'd1;
        end
        if (run_cnt_d == LIMIT) hang_d = 1'b1;
    end

    // Counter and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            run_cnt_q      <= 10'd0;
            hang_q         <= 1'b0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            run_cnt_q      <= run_cnt_d;
            hang_q         <= hang_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign hang_o         = hang_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests into the stall vector and
// converts MEM-stage exceptions/ERET into a one-cycle flush with redirect PC.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WDOG_LIMIT = 1023,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   ctrl_if
);

    pipe_state_e state_q, state_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [5:0]  stall_req;
    logic [5:0]  stall;
    logic        flush;

    assign stall_req = stall_encode(ctrl_if.stallreq_if, ctrl_if.stallreq_id,
                                    ctrl_if.stallreq_ex, ctrl_if.stallreq_mem);

    // FSM next-state and outputs: flush cycle overrides stalls; exceptions only seen in RUN.
    always_comb begin
        state_d  = state_q;
        new_pc_d = new_pc_q;
        flush    = 1'b0;
        stall    = stall_req;
        case (state_q)
            ST_RUN: begin
                if (ctrl_if.excepttype != EXC_NONE) begin
                    state_d  = ST_FLUSH;
                    new_pc_d = (ctrl_if.excepttype == EXC_ERET) ? ctrl_if.cp0_epc : EXC_VECTOR;
                end
            end
            ST_FLUSH: begin
                flush   = 1'b1;
                stall   = STALL_NONE;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State and redirect-target registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            new_pc_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            new_pc_q <= new_pc_d;
        end
    end

    pipe_ctrl_stall_wdog #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_stall_wdog (
        .clk            (clk),
        .rst            (rst),
        .stall_any_i    (stall != STALL_NONE),
        .stall_cycles_o (ctrl_if.stall_cycles),
        .hang_o         (ctrl_if.hang)
    );

    assign ctrl_if.stall  = stall;
    assign ctrl_if.flush  = flush;
    assign ctrl_if.new_pc = new_pc_q;
    assign ctrl_if.state  = state_q;

endmodule
